// File: rtl/seq_adder_n.sv
// seq_adder_n: multi-cycle WIDTH-bit adder that processes CHUNK bits per clock,
// chaining one CHUNK-bit adder slice through a registered carry.
// Valid/ready handshake on both the operand and the result side.
//
// Optional feature (compile-time macro SEQ_ADDER_SUB_EN):
//   adds input 'sub' (a - b when high, cin ignored) and output 'ovf'
//   (signed overflow of the final result). Without the macro the block is a
//   pure adder and neither port exists.
//
// WIDTH must be an integer multiple of CHUNK, with 1 <= CHUNK <= WIDTH.

module seq_adder_n #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
`ifdef SEQ_ADDER_SUB_EN
  input  logic             sub,
  output logic             ovf,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             busy
);

  localparam int unsigned NCH  = WIDTH / CHUNK;
  localparam int unsigned IDXW = (NCH > 1) ? $clog2(NCH) : 1;
  localparam logic [IDXW-1:0] LastIdx = IDXW'(NCH - 1);

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDone
  } state_e;

  state_e           state_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic             carry_q;
  logic [IDXW-1:0]  idx_q;

  logic [CHUNK-1:0] a_chunk;
  logic [CHUNK-1:0] b_chunk;
  logic [CHUNK-1:0] s_chunk;
  logic             c_chunk;
  logic             last_chunk;
`ifdef SEQ_ADDER_SUB_EN
  logic             ovf_chunk;
`endif

  // One CHUNK-bit slice of the add, selected by the chunk index.
  always_comb begin
    a_chunk = a_q[idx_q*CHUNK +: CHUNK];
    b_chunk = b_q[idx_q*CHUNK +: CHUNK];
    {c_chunk, s_chunk} = {1'b0, a_chunk} + {1'b0, b_chunk} + {{CHUNK{1'b0}}, carry_q};
    last_chunk = (idx_q == LastIdx);
`ifdef SEQ_ADDER_SUB_EN
    // Carry into the MSB is recovered from the MSB sum bit; only meaningful
    // on the last chunk, where the MSB of the slice is the MSB of the word.
    ovf_chunk = c_chunk ^ (a_chunk[CHUNK-1] ^ b_chunk[CHUNK-1] ^ s_chunk[CHUNK-1]);
`endif
  end

  // Control FSM with registered handshake outputs and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      a_q       <= '0;
      b_q       <= '0;
      carry_q   <= 1'b0;
      idx_q     <= '0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      sum       <= '0;
      cout      <= 1'b0;
`ifdef SEQ_ADDER_SUB_EN
      ovf       <= 1'b0;
`endif
    end else begin
      unique case (state_q)
        StIdle: begin
          if (in_valid && in_ready) begin
            a_q <= a;
`ifdef SEQ_ADDER_SUB_EN
            // a - b computed as a + ~b + 1.
            b_q     <= sub ? ~b : b;
            carry_q <= sub | cin;
`else
            b_q     <= b;
            carry_q <= cin;
`endif
            idx_q    <= '0;
            in_ready <= 1'b0;
            busy     <= 1'b1;
            state_q  <= StRun;
          end
        end
        StRun: begin
          // Unwritten chunks of sum keep their previous contents.
          sum[idx_q*CHUNK +: CHUNK] <= s_chunk;
          carry_q <= c_chunk;
          idx_q   <= idx_q + 1'b1;
          if (last_chunk) begin
            cout      <= c_chunk;
`ifdef SEQ_ADDER_SUB_EN
            ovf       <= ovf_chunk;
`endif
            out_valid <= 1'b1;
            state_q   <= StDone;
          end
        end
        StDone: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            busy      <= 1'b0;
            state_q   <= StIdle;
          end
        end
        default: begin
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
          busy      <= 1'b0;
          state_q   <= StIdle;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_adder_n.sv
// Directed testbench for seq_adder_n: three instances (CHUNK = 4, 1, 16) at
// WIDTH = 16 share the operand inputs so latency can be compared per build.
// Define SEQ_ADDER_SUB_EN for both RTL and bench to exercise subtraction.

module tb_seq_adder_n;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        in_valid;
  logic        out_ready;
  logic        cin;
  logic [15:0] a;
  logic [15:0] b;
`ifdef SEQ_ADDER_SUB_EN
  logic        sub;
  logic        ovf4, ovf1, ovf16;
`endif

  logic        in_ready4, out_valid4, cout4, busy4;
  logic [15:0] sum4;
  logic        in_ready1, out_valid1, cout1, busy1;
  logic [15:0] sum1;
  logic        in_ready16, out_valid16, cout16, busy16;
  logic [15:0] sum16;

  int n_tests = 0;
  int n_fail  = 0;

  seq_adder_n #(.WIDTH(16), .CHUNK(4)) u_dut4 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready4),
    .a         (a),
    .b         (b),
    .cin       (cin),
`ifdef SEQ_ADDER_SUB_EN
    .sub       (sub),
    .ovf       (ovf4),
`endif
    .out_valid (out_valid4),
    .out_ready (out_ready),
    .sum       (sum4),
    .cout      (cout4),
    .busy      (busy4)
  );

  seq_adder_n #(.WIDTH(16), .CHUNK(1)) u_dut1 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready1),
    .a         (a),
    .b         (b),
    .cin       (cin),
`ifdef SEQ_ADDER_SUB_EN
    .sub       (sub),
    .ovf       (ovf1),
`endif
    .out_valid (out_valid1),
    .out_ready (out_ready),
    .sum       (sum1),
    .cout      (cout1),
    .busy      (busy1)
  );

  seq_adder_n #(.WIDTH(16), .CHUNK(16)) u_dut16 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready16),
    .a         (a),
    .b         (b),
    .cin       (cin),
`ifdef SEQ_ADDER_SUB_EN
    .sub       (sub),
    .ovf       (ovf16),
`endif
    .out_valid (out_valid16),
    .out_ready (out_ready),
    .sum       (sum16),
    .cout      (cout16),
    .busy      (busy16)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // One full transaction with out_ready held low until every instance is done.
  task automatic do_op(input logic [15:0] ta, input logic [15:0] tbv, input logic tcin,
                       input logic [15:0] es, input logic ec);
    int l4;
    int l1;
    int l16;
`ifdef SEQ_ADDER_SUB_EN
    logic [15:0] bb;
    logic        eo;
    bb = sub ? ~tbv : tbv;
    eo = (ta[15] == bb[15]) && (es[15] != ta[15]);
`endif
    l4  = -1;
    l1  = -1;
    l16 = -1;
    @(negedge clk);
    check("idle_in_ready", {in_ready4, in_ready1, in_ready16}, 3'b111);
    a         = ta;
    b         = tbv;
    cin       = tcin;
    in_valid  = 1'b1;
    out_ready = 1'b0;
    @(posedge clk); #1;
    // Operands must already be latched; scramble the inputs.
    in_valid = 1'b0;
    a        = ~ta;
    b        = ~tbv;
    cin      = ~tcin;
    check("accept_in_ready", {in_ready4, in_ready1, in_ready16}, 3'b000);
    for (int cyc = 1; cyc <= 18; cyc++) begin
      @(negedge clk);
      in_valid = (cyc % 3 == 0);
      @(posedge clk); #1;
      check("in_ready_low", {in_ready4, in_ready1, in_ready16}, 3'b000);
      check("busy_high", {busy4, busy1, busy16}, 3'b111);
      if (out_valid4) begin
        if (l4 < 0) l4 = cyc;
        check("sum4", {15'd0, cout4, sum4}, {15'd0, ec, es});
`ifdef SEQ_ADDER_SUB_EN
        check("ovf4", {31'd0, ovf4}, {31'd0, eo});
`endif
      end
      if (out_valid1) begin
        if (l1 < 0) l1 = cyc;
        check("sum1", {15'd0, cout1, sum1}, {15'd0, ec, es});
`ifdef SEQ_ADDER_SUB_EN
        check("ovf1", {31'd0, ovf1}, {31'd0, eo});
`endif
      end
      if (out_valid16) begin
        if (l16 < 0) l16 = cyc;
        check("sum16", {15'd0, cout16, sum16}, {15'd0, ec, es});
`ifdef SEQ_ADDER_SUB_EN
        check("ovf16", {31'd0, ovf16}, {31'd0, eo});
`endif
      end
    end
    check("lat4", l4, 4);
    check("lat1", l1, 16);
    check("lat16", l16, 1);
    @(negedge clk);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    check("hs_out_valid", {out_valid4, out_valid1, out_valid16}, 3'b000);
    check("hs_in_ready", {in_ready4, in_ready1, in_ready16}, 3'b111);
    check("hs_busy", {busy4, busy1, busy16}, 3'b000);
    out_ready = 1'b0;
  endtask

  // out_ready high before out_valid: the CHUNK=4 result is taken on its first DONE edge.
  task automatic do_fast(input logic [15:0] ta, input logic [15:0] tbv,
                         input logic [15:0] es, input logic ec);
    @(negedge clk);
    a         = ta;
    b         = tbv;
    cin       = 1'b0;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("fast_not_yet", {31'd0, out_valid4}, 32'd0);
    @(posedge clk); #1;
    check("fast_valid", {31'd0, out_valid4}, 32'd1);
    check("fast_sum", {15'd0, cout4, sum4}, {15'd0, ec, es});
    @(posedge clk); #1;
    check("fast_drop", {30'd0, out_valid4, in_ready4}, 32'd1);
    repeat (14) @(posedge clk);
    #1;
    check("fast_all_idle", {in_ready4, in_ready1, in_ready16}, 3'b111);
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  initial begin
    logic [15:0] ra;
    logic [15:0] rb;
    logic        rc;
    logic [16:0] rs;

    rst_n     = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    cin       = 1'b0;
    a         = '0;
    b         = '0;
`ifdef SEQ_ADDER_SUB_EN
    sub       = 1'b0;
`endif
    #2 rst_n = 1'b0;
    #2;
    check("rst_ctrl4", {in_ready4, out_valid4, busy4, cout4}, 4'b1000);
    check("rst_sum4", {16'd0, sum4}, 32'd0);
    check("rst_ctrl_others", {in_ready1, out_valid1, in_ready16, out_valid16}, 4'b1010);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Directed additions.
    do_op(16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0);
    do_op(16'h0FFF, 16'h0001, 1'b0, 16'h1000, 1'b0);
    do_op(16'hFFFF, 16'h0000, 1'b1, 16'h0000, 1'b1);
    do_op(16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1);
    do_op(16'hAAAA, 16'h5555, 1'b1, 16'h0000, 1'b1);
    do_op(16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0);

    do_fast(16'h00F0, 16'h0F10, 16'h1000, 1'b0);

    // Reset two cycles into a run: result discarded immediately.
    @(negedge clk);
    a        = 16'h1111;
    b        = 16'h2222;
    cin      = 1'b0;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("midrst_ctrl", {in_ready4, out_valid4, busy4, cout4}, 4'b1000);
    check("midrst_sum", {16'd0, sum4}, 32'd0);
    check("midrst_others", {in_ready1, in_ready16, busy1, busy16}, 4'b1100);
    @(negedge clk);
    rst_n = 1'b1;
    do_op(16'h0003, 16'h0004, 1'b0, 16'h0007, 1'b0);

    // Random operands against a plain 17-bit addition.
    for (int i = 0; i < 30; i++) begin
      ra = 16'($urandom);
      rb = 16'($urandom);
      rc = 1'($urandom_range(1, 0));
      rs = {1'b0, ra} + {1'b0, rb} + {16'd0, rc};
      do_op(ra, rb, rc, rs[15:0], rs[16]);
    end

`ifdef SEQ_ADDER_SUB_EN
    sub = 1'b1;
    do_op(16'h0005, 16'h0007, 1'b1, 16'hFFFE, 1'b0);
    do_op(16'h8000, 16'h0001, 1'b0, 16'h7FFF, 1'b1);
    do_op(16'h0007, 16'h0005, 1'b0, 16'h0002, 1'b1);
    sub = 1'b0;
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
